// File: rtl/median_pkg.sv
// Shared definitions for the median/rank filter pipeline.
//   mode_e     : per-window operation (median, min, max, reserved = median)
//   DATA_W_DEF : default pixel width used by median_rank_pipe
package median_pkg;

    typedef enum logic [1:0] {
        MODE_MEDIAN = 2'b00,
        MODE_MIN    = 2'b01,
        MODE_MAX    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/median_rank_pipe_sort3_asc.sv
// sort3_asc: combinational ascending sort of three unsigned values.
// Ports:
//   a, b, c : DATA_W-bit inputs
//   min     : smallest of the three
//   mid     : middle value
//   max     : largest of the three
// Equal inputs resolve to the same value on every output that selects them,
// so ties are deterministic.
module sort3_asc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] mid,
    output logic [DATA_W-1:0] max
);

    logic [DATA_W-1:0] ab_lo_s;
    logic [DATA_W-1:0] ab_hi_s;
    logic [DATA_W-1:0] hc_lo_s;

    // Three compare-exchange steps: (a,b), (hi,c), (lo,hc_lo).
    always_comb begin
        ab_lo_s = (a <= b) ? a : b;
        ab_hi_s = (a <= b) ? b : a;
        hc_lo_s = (ab_hi_s <= c) ? ab_hi_s : c;
        max     = (ab_hi_s <= c) ? c : ab_hi_s;
        min     = (ab_lo_s <= hc_lo_s) ? ab_lo_s : hc_lo_s;
        mid     = (ab_lo_s <= hc_lo_s) ? hc_lo_s : ab_lo_s;
    end

endmodule

// File: rtl/median_rank_pipe.sv
// median_rank_pipe: 3-stage 3x3 median / min / max filter.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : input handshake (in_ready = pipeline enable)
//   window [9*DATA_W]    : pixel k at [k*DATA_W +: DATA_W], rows of three
//   mode [MODE_W]        : 00 median, 01 min, 10 max, 11 median
//   out_valid, out_ready : output handshake
//   pixel_out [DATA_W]   : filtered result (registered)
//   win_count [32]       : handshake counter, only with MEDIAN_RANK_CNT_EN
// S1 sorts each row, S2 forms max-of-mins / mid-of-mids / min-of-maxes plus
// global min/max, S3 selects the result. One enable stalls every stage.
module median_rank_pipe
    import median_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MODE_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*DATA_W-1:0]   window,
    input  logic [MODE_W-1:0]     mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     pixel_out
`ifdef MEDIAN_RANK_CNT_EN
    ,
    output logic [31:0]           win_count
`endif
);

    // Median of three, used on the S2 candidates.
    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] hc;
        lo = (a <= b) ? a : b;
        hi = (a <= b) ? b : a;
        hc = (hi <= c) ? hi : c;
        return (lo <= hc) ? hc : lo;
    endfunction

    logic en_s;

    logic [DATA_W-1:0] row_mn_s [3];
    logic [DATA_W-1:0] row_md_s [3];
    logic [DATA_W-1:0] row_mx_s [3];

    logic [DATA_W-1:0] s1_mn_r [3];
    logic [DATA_W-1:0] s1_md_r [3];
    logic [DATA_W-1:0] s1_mx_r [3];
    logic [MODE_W-1:0] s1_mode_r;
    logic              s1_valid_r;

    logic [DATA_W-1:0] gmin_s, lo_s, unused_mn_mid_s;
    logic [DATA_W-1:0] unused_md_lo_s, md_s, unused_md_hi_s;
    logic [DATA_W-1:0] hi_s, unused_mx_mid_s, gmax_s;

    logic [DATA_W-1:0] s2_lo_r, s2_md_r, s2_hi_r, s2_gmin_r, s2_gmax_r;
    logic [MODE_W-1:0] s2_mode_r;
    logic              s2_valid_r;

    logic [DATA_W-1:0] sel_s;

    // A stage may advance when the output slot is empty or being drained.
    always_comb begin
        en_s     = out_ready | ~out_valid;
        in_ready = en_s;
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        sort3_asc #(.DATA_W(DATA_W)) u_row (
            .a   (window[(3*r+0)*DATA_W +: DATA_W]),
            .b   (window[(3*r+1)*DATA_W +: DATA_W]),
            .c   (window[(3*r+2)*DATA_W +: DATA_W]),
            .min (row_mn_s[r]),
            .mid (row_md_s[r]),
            .max (row_mx_s[r])
        );
    end

    // S1: register sorted rows, mode and valid (bubble when in_valid is low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= MODE_MEDIAN;
            for (int r = 0; r < 3; r++) begin
                s1_mn_r[r] <= {DATA_W{1'b0}};
                s1_md_r[r] <= {DATA_W{1'b0}};
                s1_mx_r[r] <= {DATA_W{1'b0}};
            end
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            s1_mode_r  <= mode;
            for (int r = 0; r < 3; r++) begin
                s1_mn_r[r] <= row_mn_s[r];
                s1_md_r[r] <= row_md_s[r];
                s1_mx_r[r] <= row_mx_s[r];
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Column sorts: the max of row mins, mid of row mids and min of row maxes
    // bracket the median; min of mins / max of maxes are the global extrema.
    sort3_asc #(.DATA_W(DATA_W)) u_mins (
        .a(s1_mn_r[0]), .b(s1_mn_r[1]), .c(s1_mn_r[2]),
        .min(gmin_s), .mid(unused_mn_mid_s), .max(lo_s)
    );
    sort3_asc #(.DATA_W(DATA_W)) u_mids (
        .a(s1_md_r[0]), .b(s1_md_r[1]), .c(s1_md_r[2]),
        .min(unused_md_lo_s), .mid(md_s), .max(unused_md_hi_s)
    );
    sort3_asc #(.DATA_W(DATA_W)) u_maxs (
        .a(s1_mx_r[0]), .b(s1_mx_r[1]), .c(s1_mx_r[2]),
        .min(hi_s), .mid(unused_mx_mid_s), .max(gmax_s)
    );

    // S2: register median candidates, extrema, mode and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_mode_r  <= MODE_MEDIAN;
            s2_lo_r    <= {DATA_W{1'b0}};
            s2_md_r    <= {DATA_W{1'b0}};
            s2_hi_r    <= {DATA_W{1'b0}};
            s2_gmin_r  <= {DATA_W{1'b0}};
            s2_gmax_r  <= {DATA_W{1'b0}};
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_mode_r  <= s1_mode_r;
            s2_lo_r    <= lo_s;
            s2_md_r    <= md_s;
            s2_hi_r    <= hi_s;
            s2_gmin_r  <= gmin_s;
            s2_gmax_r  <= gmax_s;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Result select; the reserved encoding falls back to median.
    always_comb begin
        sel_s = med3(s2_lo_r, s2_md_r, s2_hi_r);
        case (s2_mode_r)
            MODE_MIN: sel_s = s2_gmin_r;
            MODE_MAX: sel_s = s2_gmax_r;
            default:  sel_s = med3(s2_lo_r, s2_md_r, s2_hi_r);
        endcase
    end

    // S3: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            pixel_out <= {DATA_W{1'b0}};
        end else if (en_s) begin
            out_valid <= s2_valid_r;
            pixel_out <= sel_s;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef MEDIAN_RANK_CNT_EN
    // Count completed output handshakes, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count <= 32'd0;
        end else if (out_valid && out_ready) begin
            win_count <= win_count + 32'd1;
        end else begin
            win_count <= win_count;
        end
    end
`endif

endmodule

// File: tb/tb_median_rank_pipe.sv
// Scoreboard bench for median_rank_pipe (DATA_W = 12). Stimulus pushes the
// hand-computed result per accepted window; a negedge monitor pops and
// compares on every output handshake. Define MEDIAN_RANK_CNT_EN to also
// check win_count.
module tb_median_rank_pipe;

    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] val;
        int            acc;
        bit            lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [9*DW-1:0] window;
    logic [1:0]      mode;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   pixel_out;
`ifdef MEDIAN_RANK_CNT_EN
    logic [31:0]     win_count;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   hs_cnt = 0;
    bit   lat_en = 1'b1;

    median_rank_pipe #(.DATA_W(DW), .MODE_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .window    (window),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pixel_out (pixel_out)
`ifdef MEDIAN_RANK_CNT_EN
        ,
        .win_count (win_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] mk(input int p0, input int p1, input int p2,
                                            input int p3, input int p4, input int p5,
                                            input int p6, input int p7, input int p8);
        logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
        a0 = p0[DW-1:0]; a1 = p1[DW-1:0]; a2 = p2[DW-1:0];
        a3 = p3[DW-1:0]; a4 = p4[DW-1:0]; a5 = p5[DW-1:0];
        a6 = p6[DW-1:0]; a7 = p7[DW-1:0]; a8 = p8[DW-1:0];
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Present one window until accepted; push its expected result if asked.
    task automatic send(input logic [9*DW-1:0] w, input logic [1:0] m,
                        input int exp, input bit push);
        bit   done;
        exp_t e;
        done = 1'b0;
        in_valid = 1'b1;
        window = w;
        mode = m;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) begin
                    e.val = exp[DW-1:0];
                    e.acc = cyc;
                    e.lat = lat_en;
                    q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", {20'd0, pixel_out}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("pixel_out", {20'd0, pixel_out}, {20'd0, e.val});
                if (e.lat) check("latency", cyc - e.acc, 32'd3);
            end
            n_out++;
            hs_cnt++;
        end
    end

    initial begin
        logic [DW-1:0] held;
        int            base;
        bit            stall_done;
        logic [31:0]   wc0;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        window = '0;
        mode = 2'b00;
        wc0 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pixel_out", {20'd0, pixel_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Basic median, then the same window in min / max / reserved modes.
        send(mk(9, 8, 7, 6, 5, 4, 3, 2, 1), 2'b00, 5, 1'b1);
        send(mk(9, 8, 7, 6, 5, 4, 3, 2, 1), 2'b01, 1, 1'b1);
        send(mk(9, 8, 7, 6, 5, 4, 3, 2, 1), 2'b10, 9, 1'b1);
        send(mk(9, 8, 7, 6, 5, 4, 3, 2, 1), 2'b11, 5, 1'b1);
        send(mk(3, 1, 2, 9, 7, 8, 6, 4, 5), 2'b00, 5, 1'b1);
        send(mk(10, 10, 20, 20, 20, 5, 5, 5, 10), 2'b00, 10, 1'b1);
        send(mk(10, 10, 20, 20, 20, 5, 5, 5, 10), 2'b01, 5, 1'b1);
        send(mk(10, 10, 20, 20, 20, 5, 5, 5, 10), 2'b10, 20, 1'b1);
        send(mk(200, 1, 1, 200, 1, 1, 200, 200, 200), 2'b00, 200, 1'b1);
        // Full-scale extremes and all-equal pixels.
        send(mk(4095, 0, 4095, 0, 4095, 0, 4095, 0, 4095), 2'b00, 4095, 1'b1);
        send(mk(4095, 0, 4095, 0, 4095, 0, 4095, 0, 4095), 2'b01, 0, 1'b1);
        send(mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'b00, 100, 1'b1);
        drain();

        // Stream 5 windows; stall the consumer 4 clk at the third output.
        lat_en = 1'b0;
        base = n_out;
        stall_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(mk(30*i+3, 30*i+1, 30*i+2, 30*i+9, 30*i+7,
                            30*i+8, 30*i+6, 30*i+4, 30*i+5), 2'b00, 30*i+5, 1'b1);
            end
            begin
                for (int t = 0; t < 60 && !stall_done; t++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid && n_out == base + 2) begin
                        held = pixel_out;
`ifdef MEDIAN_RANK_CNT_EN
                        wc0 = win_count;
`endif
                        out_ready = 1'b0;
                        for (int s = 0; s < 4; s++) begin
                            @(negedge clk);
                            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                            check("stall_hold", {20'd0, pixel_out}, {20'd0, held});
`ifdef MEDIAN_RANK_CNT_EN
                            check("stall_count", win_count, wc0);
`endif
                            @(posedge clk);
                            #1;
                        end
                        out_ready = 1'b1;
                        stall_done = 1'b1;
                    end
                end
                check("stall_seen", {31'd0, stall_done}, 32'd1);
            end
        join
        drain();
        check("stream_count", n_out - base, 32'd5);
        lat_en = 1'b1;
`ifdef MEDIAN_RANK_CNT_EN
        check("win_count", win_count, hs_cnt);
`endif

        // Reset with two windows in flight: nothing may come out.
        send(mk(1, 2, 3, 4, 5, 6, 7, 8, 9), 2'b00, 5, 1'b0);
        send(mk(1, 2, 3, 4, 5, 6, 7, 8, 9), 2'b10, 9, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_pixel", {20'd0, pixel_out}, 32'd0);
        hs_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(mk(3, 1, 2, 9, 7, 8, 6, 4, 5), 2'b10, 9, 1'b1);
        drain();
`ifdef MEDIAN_RANK_CNT_EN
        check("win_count_after_rst", win_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
